// File: rtl/mux_nx1_serializer_if.sv
// Lane-bus interface for the N:1 serializer: parallel frame load side plus
// the registered serial word stream and status flags.
interface mux_nx1_serializer_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8
);
  localparam int IDX_W = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES*DATA_W-1:0] in_data;
  logic [NUM_LANES-1:0]        in_valid;
  logic                        in_load;
  logic                        in_ready;
  logic [DATA_W-1:0]           out;
  logic                        validout;
  logic [IDX_W-1:0]            lane_idx;
  logic                        frame_end;
  logic                        overrun_err;

  modport master (
    output in_data, in_valid, in_load,
    input  in_ready, out, validout, lane_idx, frame_end, overrun_err
  );

  modport slave (
    input  in_data, in_valid, in_load,
    output in_ready, out, validout, lane_idx, frame_end, overrun_err
  );
endinterface

// File: rtl/mux_nx1_serializer.sv
// N:1 lane serializer: captures a frame of NUM_LANES words and emits them one
// per cycle, optionally skipping invalid lanes, with back-to-back frame reload.
module mux_nx1_serializer #(
  parameter int NUM_LANES    = 4,
  parameter int DATA_W       = 8,
  parameter int SKIP_INVALID = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  mux_nx1_serializer_if.slave   bus
);
  localparam int IDX_W = (NUM_LANES > 2) ? $clog2(NUM_LANES) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [IDX_W-1:0]            ptr_q, ptr_d;
  logic [NUM_LANES*DATA_W-1:0] buf_q, buf_d;
  logic [NUM_LANES-1:0]        vld_q, vld_d;
  logic [DATA_W-1:0]           out_q, out_d;
  logic                        validout_q, validout_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        fend_q, fend_d;
  logic                        ovr_q, ovr_d;

  logic                        last_s;
  logic                        ready_s;
  logic                        accept_s;
  logic                        nonempty_s;
  logic [IDX_W-1:0]            last_lane_s;
  logic [IDX_W-1:0]            first_lane_s;
  logic [IDX_W-1:0]            next_lane_s;

  // Lowest set bit strictly above position 'above' (pass -1 for the lowest overall).
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_LANES-1:0] v,
                                                  input int above);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (v[i] && (i > above)) begin
        r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] highest_set(input logic [NUM_LANES-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  // Lane sequencing helpers: skip mode walks only the set valid bits.
  always_comb begin
    if (SKIP_INVALID != 0) begin
      last_lane_s  = highest_set(vld_q);
      first_lane_s = lowest_set(bus.in_valid, -1);
      next_lane_s  = lowest_set(vld_q, int'(ptr_q));
      nonempty_s   = |bus.in_valid;
    end else begin
      last_lane_s  = IDX_W'(NUM_LANES - 1);
      first_lane_s = '0;
      next_lane_s  = ptr_q + IDX_W'(1);
      nonempty_s   = 1'b1;
    end
  end

  assign last_s   = (state_q == SEND) && (ptr_q == last_lane_s);
  assign ready_s  = (state_q == IDLE) || last_s;
  assign accept_s = bus.in_load && ready_s;

  // Next-state, buffer capture and registered-output decode.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    buf_d      = buf_q;
    vld_d      = vld_q;
    out_d      = '0;
    validout_d = 1'b0;
    idx_d      = '0;
    fend_d     = 1'b0;
    ovr_d      = ovr_q | (bus.in_load & ~ready_s);

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SEND: begin
        out_d      = buf_q[int'(ptr_q)*DATA_W +: DATA_W];
        idx_d      = ptr_q;
        validout_d = (SKIP_INVALID != 0) ? 1'b1 : vld_q[ptr_q];
        fend_d     = last_s;
        if (last_s) begin
          state_d = IDLE;
        end else begin
          ptr_d = next_lane_s;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase

    // A reload on the last-lane cycle overrides the return to IDLE.
    if (accept_s) begin
      buf_d   = bus.in_data;
      vld_d   = bus.in_valid;
      ptr_d   = first_lane_s;
      state_d = nonempty_s ? SEND : IDLE;
    end else begin
      buf_d = buf_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      buf_q      <= '0;
      vld_q      <= '0;
      out_q      <= '0;
      validout_q <= 1'b0;
      idx_q      <= '0;
      fend_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      buf_q      <= buf_d;
      vld_q      <= vld_d;
      out_q      <= out_d;
      validout_q <= validout_d;
      idx_q      <= idx_d;
      fend_q     <= fend_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.in_ready    = ready_s;
  assign bus.out         = out_q;
  assign bus.validout    = validout_q;
  assign bus.lane_idx    = idx_q;
  assign bus.frame_end   = fend_q;
  assign bus.overrun_err = ovr_q;
endmodule
